// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package div_pkg;

  // Controller states; encodings are fixed so that they read the same in waveforms
  // as the companion shift-add multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width. One extra bit over log2 keeps the value N-1
  // representable for every N, including N=1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - restoring shift-subtract datapath with committed result registers
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   load                  capture operands, clear partial remainder
//   step                  perform one shift-subtract iteration
//   commit                copy this iteration's results into the result registers
//   commit_dbz            write the divide-by-zero result from the live operands
//   dividend, divisor     operand inputs (only sampled on load / commit_dbz)
//   dvsr_zero             live divisor is zero; lets the controller skip RUN
//   quotient, remainder   result registers
//   div_by_zero           status of the last completed operation
module divider_datapath #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         commit,
  input  logic         commit_dbz,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         dvsr_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  // Partial remainder. The algorithm's remainder is N+1 bits wide, but after every
  // step it is strictly below the divisor, so its top bit is always zero and only
  // the low N bits need storage.
  logic [N-1:0] r;
  logic [N-1:0] qw;
  logic [N-1:0] dw;

  logic [N:0]   rs;
  logic [N:0]   t;
  logic [N-1:0] r_nxt;
  logic [N-1:0] qw_nxt;

  assign dvsr_zero = (divisor == '0);

  always_comb begin
    rs     = {r, qw[N-1]};
    t      = rs - {1'b0, dw};
    // A borrow out of the subtract means the divisor did not fit: restore.
    r_nxt  = t[N] ? rs[N-1:0] : t[N-1:0];
    qw_nxt = {qw[N-2:0], ~t[N]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r  <= '0;
      qw <= '0;
      dw <= '0;
    end else if (load) begin
      r  <= '0;
      qw <= dividend;
      dw <= divisor;
    end else if (step) begin
      r  <= r_nxt;
      qw <= qw_nxt;
    end
  end

  // Result registers move only on a commit, so they never show partial values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (commit_dbz) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (commit) begin
      quotient    <= qw_nxt;
      remainder   <= r_nxt;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk                   clock, rising edge
//   rst                   asynchronous active-low reset
//   start                 request, sampled only in IDLE
//   dividend, divisor     operands, captured on the accepting edge
//   busy                  high while iterating
//   done                  one-cycle completion pulse
//   quotient, remainder   results, held until the next completion
//   div_by_zero           last completed operation had a zero divisor
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic load;
  logic step;
  logic commit;
  logic commit_dbz;
  logic dvsr_zero;

  // Datapath strobes are decoded from the current state so they act on the same
  // edge that the controller changes state.
  always_comb begin
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    commit_dbz = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          commit_dbz = dvsr_zero;
        end
      end
      RUN: begin
        step   = 1'b1;
        commit = (cnt == LAST);
      end
      default: ;
    endcase
  end

  // busy/done are registered alongside the state so they are clean Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (dvsr_zero) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  divider_datapath #(
    .N(N)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .commit     (commit),
    .commit_dbz (commit_dbz),
    .dividend   (dividend),
    .divisor    (divisor),
    .dvsr_zero  (dvsr_zero),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

endmodule
